demuxi1_4: RTL and testbench
============================

// Module: demuxi1_4
// PURPOSE
//  Registered 1:4 demultiplexer, the distribution counterpart of the 4:1 selector muxi4_1.
//  Steers one WIDTH-bit input stream to one of four output channels.
//  Each channel is a one-entry buffered valid/ready slot.
//  Destination is either addressed by in_sel or chosen round-robin (rr_en=1).
//  Sits between a single producer and four independent consumers.
// PARAMETERS
//  WIDTH     2   data width of input and of each output channel
//  CNT_W     8   width of the accepted-transfer counter
// PORTS
//  clk        in   1        single clock; all state updates on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        producer has data
//  in_ready   out  1        demux accepts data this cycle
//  in_data    in   WIDTH    payload
//  in_sel     in   2        destination channel when rr_en=0
//  rr_en      in   1        1: destination = internal rr_ptr, in_sel ignored
//  out_valid  out  4        bit k: channel k slot holds data
//  out_ready  in   4        bit k: consumer k takes data this cycle
//  out_data0..out_data3  out  WIDTH  slot contents of channel 0..3
//  rr_ptr     out  2        current round-robin pointer
//  xfer_cnt   out  CNT_W    number of accepted input transfers, wraps
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=4'b0000, out_data*=0, rr_ptr=0, xfer_cnt=0. Mid-operation
//   reset discards all buffered data immediately, without waiting for a clock edge.
//  tgt = rr_en ? rr_ptr : in_sel (combinational).
//  in_ready = ~out_valid[tgt] | out_ready[tgt] (combinational path from out_ready allowed).
//  accept = in_valid & in_ready; output pop k = out_valid[k] & out_ready[k].
//  Slot k states EMPTY/FULL:
//   EMPTY + accept to k        -> FULL, data latched
//   FULL + pop k, no accept    -> EMPTY
//   FULL + pop k + accept to k -> stays FULL, new data latched (full throughput)
//   FULL, no pop               -> holds data stable; out_data must not change while out_valid=1
//  Latency: data accepted at edge N is visible on out_valid/out_data at N+1 (1 cycle).
//  Only slot tgt can be written in a cycle; the other slots drain independently.
//  rr_ptr: advances only on accept while rr_en=1: 0->1->2->3->0. Holds when rr_en=0.
//   Toggling rr_en does not reset the pointer.
//   Strict order: the pointer does not skip a FULL slot; in_ready stays low until that slot drains.
//  xfer_cnt: +1 on every accept, wraps 2^CNT_W-1 -> 0.
//  in_valid=0: no state changes except pops. in_sel/in_data are don't-care when in_valid=0.
//  out_data* of an EMPTY slot retains its last value (not cleared).
// STRUCTURE
//  Package demux_pkg: localparam NOUT=4, SEL_W=2; typedef logic [SEL_W-1:0] sel_t;
//   typedef enum {SLOT_EMPTY, SLOT_FULL} slot_state_t.
//  Sub-module demuxi_slot (one-entry valid/ready register slice, WIDTH parameter):
//   instantiated 4x via generate.
//  Top level: tgt decode, in_ready mux, rr_ptr counter, xfer_cnt counter.
// TESTING
//  1. rr_en=0, out_ready=4'hF, send in_data=0,1,2,3 with in_sel=0,1,2,3 on consecutive cycles
//     -> each out_data_k=k with out_valid[k]=1 exactly one cycle later; xfer_cnt=4.
//  2. out_ready=0, in_sel=2, send 2'b10 then 2'b11 -> first accepted; in_ready=0 on second;
//     out_data2 holds 2'b10; raise out_ready[2] -> 2'b11 accepted the same cycle.
//  3. rr_en=1, all ready, 6 transfers of 2'b01 -> written to channels 0,1,2,3,0,1; rr_ptr ends at 2.
//  4. rr_en=1, channel 1 FULL with out_ready[1]=0, rr_ptr=1 -> in_ready=0, rr_ptr stays 1,
//     channel 2 gets nothing until out_ready[1]=1.
//  5. Slots 0 and 3 FULL, assert rst_n=0 between clock edges -> out_valid=0 immediately;
//     rr_ptr=0, xfer_cnt=0.
//  6. 256 accepted transfers -> xfer_cnt wraps from 8'hFF to 8'h00.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:4 registered demultiplexer.
package demux_pkg;

    localparam int unsigned NOUT  = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

endpackage

// File: rtl/demuxi_slot.sv
// One-entry valid/ready register slice; a write while full is only issued
// together with a pop, so the slot sustains one transfer per cycle.
module demuxi_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    slot_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (wr_en_i) begin
                    state_d = SLOT_FULL;
                    data_d  = wr_data_i;
                end
            end
            SLOT_FULL: begin
                if (wr_en_i) begin
                    data_d = wr_data_i;
                end else if (rd_ready_i) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/demuxi1_4.sv
// Registered 1:4 demultiplexer: addressed or strict round-robin steering of
// one valid/ready stream into four one-entry output slots.
module demuxi1_4
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             rr_en,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [1:0]       rr_ptr,
    output logic [CNT_W-1:0] xfer_cnt
);

    sel_t             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    sel_t             tgt;
    logic             accept;
    logic [NOUT-1:0]  wr_en;
    logic [WIDTH-1:0] slot_data [NOUT];

    // The pointer never skips a busy slot: in_ready simply waits for it.
    assign tgt      = rr_en ? rr_ptr_q : in_sel;
    assign in_ready = ~out_valid[tgt] | out_ready[tgt];
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        assign wr_en[k] = accept && (tgt == sel_t'(k));

        demuxi_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en_i   (wr_en[k]),
            .wr_data_i (in_data),
            .rd_ready_i(out_ready[k]),
            .valid_o   (out_valid[k]),
            .data_o    (slot_data[k])
        );
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        xfer_cnt_d = xfer_cnt_q;
        if (accept) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
            if (rr_en) begin
                rr_ptr_d = rr_ptr_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            xfer_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign out_data3 = slot_data[3];
    assign rr_ptr    = rr_ptr_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_demuxi1_4.sv
// Directed self-checking bench for demuxi1_4 with hand-computed expectations.
module tb_demuxi1_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic [1:0] in_sel;
    logic       rr_en;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] out_data0, out_data1, out_data2, out_data3;
    logic [1:0] rr_ptr;
    logic [7:0] xfer_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    demuxi1_4 #(
        .WIDTH(2),
        .CNT_W(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .rr_en    (rr_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data0(out_data0),
        .out_data1(out_data1),
        .out_data2(out_data2),
        .out_data3(out_data3),
        .rr_ptr   (rr_ptr),
        .xfer_cnt (xfer_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        rr_en     = 1'b0;
        out_ready = '0;
        #2;
        check("rst_out_valid", out_valid, 4'b0000);
        check("rst_rr_ptr", rr_ptr, 2'd0);
        check("rst_xfer_cnt", xfer_cnt, 8'd0);
        check("rst_data0", out_data0, 2'd0);
        check("rst_in_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;

        // 1: addressed, all consumers ready
        out_ready = 4'hF;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_sel  = 2'(k);
            in_data = 2'(k);
            step();
            check($sformatf("t1_valid%0d", k), out_valid, 32'(1 << k));
        end
        in_valid = 1'b0;
        check("t1_xfer", xfer_cnt, 8'd4);
        check("t1_data0", out_data0, 2'd0);
        check("t1_data1", out_data1, 2'd1);
        check("t1_data2", out_data2, 2'd2);
        check("t1_data3", out_data3, 2'd3);
        step();
        check("t1_drained", out_valid, 4'b0000);

        // 2: backpressure on channel 2
        out_ready = 4'b0000;
        in_sel    = 2'd2;
        in_valid  = 1'b1;
        in_data   = 2'b10;
        #1;
        check("t2_ready_empty", in_ready, 1'b1);
        step();
        check("t2_valid", out_valid, 4'b0100);
        check("t2_data_a", out_data2, 2'b10);
        in_data = 2'b11;
        #1;
        check("t2_ready_full", in_ready, 1'b0);
        step();
        check("t2_hold", out_data2, 2'b10);
        check("t2_xfer_hold", xfer_cnt, 8'd5);
        out_ready = 4'b0100;
        #1;
        check("t2_ready_pop", in_ready, 1'b1);
        step();
        check("t2_data_b", out_data2, 2'b11);
        check("t2_valid_b", out_valid, 4'b0100);
        check("t2_xfer", xfer_cnt, 8'd6);
        in_valid = 1'b0;
        step();
        check("t2_drained", out_valid, 4'b0000);

        // 3: round-robin, six transfers
        out_ready = 4'hF;
        rr_en     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 2'b01;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t3_valid%0d", i), out_valid, 32'(1 << (i % 4)));
        end
        in_valid = 1'b0;
        check("t3_rr_ptr", rr_ptr, 2'd2);
        check("t3_xfer", xfer_cnt, 8'd12);
        check("t3_data1", out_data1, 2'b01);
        step();

        // 4: pointer stalls on a full slot
        in_valid = 1'b1;
        in_data  = 2'b00;
        repeat (3) step();
        check("t4_ptr_wrap", rr_ptr, 2'd1);
        rr_en     = 1'b0;
        in_sel    = 2'd1;
        in_data   = 2'b10;
        out_ready = 4'b1101;
        step();
        check("t4_ptr_hold", rr_ptr, 2'd1);
        check("t4_xfer_a", xfer_cnt, 8'd16);
        rr_en   = 1'b1;
        in_data = 2'b11;
        #1;
        check("t4_ready_low", in_ready, 1'b0);
        step();
        step();
        check("t4_ptr_stall", rr_ptr, 2'd1);
        check("t4_only_ch1", out_valid, 4'b0010);
        check("t4_data1_hold", out_data1, 2'b10);
        check("t4_xfer_stall", xfer_cnt, 8'd16);
        out_ready = 4'hF;
        #1;
        check("t4_ready_high", in_ready, 1'b1);
        step();
        check("t4_data1_new", out_data1, 2'b11);
        check("t4_ptr_adv", rr_ptr, 2'd2);
        step();
        check("t4_ch2", out_valid, 4'b0100);
        check("t4_ptr_3", rr_ptr, 2'd3);
        check("t4_xfer_b", xfer_cnt, 8'd18);
        in_valid = 1'b0;
        step();

        // 5: async reset with slots 0 and 3 full
        rr_en     = 1'b0;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 2'b01;
        step();
        in_sel  = 2'd3;
        in_data = 2'b10;
        step();
        in_valid = 1'b0;
        check("t5_full", out_valid, 4'b1001);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_valid", out_valid, 4'b0000);
        check("t5_data0", out_data0, 2'd0);
        check("t5_data3", out_data3, 2'd0);
        check("t5_rr_ptr", rr_ptr, 2'd0);
        check("t5_xfer", xfer_cnt, 8'd0);
        step();
        rst_n = 1'b1;

        // 6: transfer counter wrap
        out_ready = 4'hF;
        in_sel    = 2'd0;
        in_valid  = 1'b1;
        repeat (255) step();
        check("t6_ff", xfer_cnt, 8'hFF);
        step();
        check("t6_wrap", xfer_cnt, 8'h00);
        in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
